// File: rtl/cdc_array_qualify.sv
// Destination-domain qualifier for a per-bit synchronized bus.
// A new word is committed to qual_out only after it has been sampled
// unchanged for STABLE_CYCLES consecutive edges, so a word caught mid-skew
// is never presented downstream.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous, active-high reset
//   sync_in      - synchronized bus from the upstream array synchronizer
//   en           - qualification enable; low freezes qual_out and drops any candidate
//   cnt_clr      - synchronous clear of update_cnt and glitch_cnt (wins over increment)
//   qual_out     - last committed stable word
//   update_pulse - one-cycle strobe in the first cycle qual_out shows a new word
//   settling     - high while a candidate is being qualified
//   update_cnt   - saturating number of commits
//   glitch_cnt   - saturating number of aborted or restarted candidates
module cdc_array_qualify #(
    parameter int unsigned      WIDTH         = 32,
    parameter int unsigned      STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_in,
    input  logic             en,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] qual_out,
    output logic             update_pulse,
    output logic             settling,
    output logic [15:0]      update_cnt,
    output logic [15:0]      glitch_cnt
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  qual_out_q, qual_out_d;
    logic              update_pulse_q, update_pulse_d;
    logic              settling_q, settling_d;
    logic [STAT_W-1:0] update_cnt_q, update_cnt_d;
    logic [STAT_W-1:0] glitch_cnt_q, glitch_cnt_d;
    logic              commit_c;
    logic              glitch_c;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cand_q         <= INIT_VALUE;
            cnt_q          <= '0;
            qual_out_q     <= INIT_VALUE;
            update_pulse_q <= 1'b0;
            settling_q     <= 1'b0;
            update_cnt_q   <= '0;
            glitch_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            qual_out_q     <= qual_out_d;
            update_pulse_q <= update_pulse_d;
            settling_q     <= settling_d;
            update_cnt_q   <= update_cnt_d;
            glitch_cnt_q   <= glitch_cnt_d;
        end
    end

    // Next state: candidate capture, stability counting, commit/abort decode
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        glitch_c = 1'b0;
        if (!en) begin
            // Disabling silently discards any candidate
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync_in != qual_out_q) begin
                        cand_d  = sync_in;
                        cnt_d   = CNT_W'(1);
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync_in == cand_q) begin
                        if (cnt_q >= CNT_LAST) begin
                            commit_c = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sync_in == qual_out_q) begin
                        // Bus fell back to the committed word: abort
                        glitch_c = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        // Bus moved to yet another word: restart on it
                        glitch_c = 1'b1;
                        cand_d   = sync_in;
                        cnt_d    = CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Outputs: committed word, strobe, status decode and statistics
    always_comb begin
        qual_out_d     = qual_out_q;
        update_pulse_d = commit_c;
        settling_d     = (state_d == SETTLE);
        update_cnt_d   = update_cnt_q;
        glitch_cnt_d   = glitch_cnt_q;
        if (commit_c) begin
            qual_out_d = cand_q;
        end
        if (cnt_clr) begin
            update_cnt_d = '0;
            glitch_cnt_d = '0;
        end else begin
            if (commit_c && (update_cnt_q != STAT_MAX)) begin
                update_cnt_d = update_cnt_q + STAT_W'(1);
            end
            if (glitch_c && (glitch_cnt_q != STAT_MAX)) begin
                glitch_cnt_d = glitch_cnt_q + STAT_W'(1);
            end
        end
    end

    assign qual_out     = qual_out_q;
    assign update_pulse = update_pulse_q;
    assign settling     = settling_q;
    assign update_cnt   = update_cnt_q;
    assign glitch_cnt   = glitch_cnt_q;

endmodule

// File: tb/tb_cdc_array_qualify.sv
// Bench for cdc_array_qualify (WIDTH=32, STABLE_CYCLES=4, INIT_VALUE=0).
// Words expected to commit are queued when driven; the monitor pops one per
// update_pulse and compares it with qual_out.
module tb_cdc_array_qualify;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sync_in;
    logic             en;
    logic             cnt_clr;
    logic [WIDTH-1:0] qual_out;
    logic             update_pulse;
    logic             settling;
    logic [15:0]      update_cnt;
    logic [15:0]      glitch_cnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_qual;
    logic [15:0]      exp_upd;
    logic [15:0]      exp_gl;

    cdc_array_qualify #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(4),
        .INIT_VALUE   ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_in     (sync_in),
        .en          (en),
        .cnt_clr     (cnt_clr),
        .qual_out    (qual_out),
        .update_pulse(update_pulse),
        .settling    (settling),
        .update_cnt  (update_cnt),
        .glitch_cnt  (glitch_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pulse must match the oldest queued word
    always @(negedge clk) begin
        if (update_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: qual_out=%h, no commit expected", qual_out);
            end else begin
                logic [WIDTH-1:0] w;
                w = exp_q.pop_front();
                if (qual_out !== w) begin
                    errors++;
                    $display("FAIL commit_word: got %h expected %h", qual_out, w);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic exp_settling);
        checks++;
        if (qual_out !== exp_qual || settling !== exp_settling ||
            update_cnt !== exp_upd || glitch_cnt !== exp_gl) begin
            errors++;
            $display("FAIL %s: qual=%h/%h settling=%b/%b upd=%h/%h gl=%h/%h (got/exp)",
                     tag, qual_out, exp_qual, settling, exp_settling,
                     update_cnt, exp_upd, glitch_cnt, exp_gl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cnt_clr = 1'b0; sync_in = '0;
        exp_qual = '0; exp_upd = '0; exp_gl = '0;
        tick(2);
        checks++;
        if (update_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: got %b expected 0", update_pulse);
        end
        check_all("reset_state", 1'b0);
        rst = 1'b0;
        tick(2);
        check_all("post_reset_idle", 1'b0);
    endtask

    task automatic test_commit();
        sync_in = 32'hA5A5_A5A5;
        exp_q.push_back(32'hA5A5_A5A5);
        tick(1);
        check_all("commit_settling_T", 1'b1);
        tick(2);
        check_all("commit_held_T2", 1'b1);
        tick(1);
        exp_qual = 32'hA5A5_A5A5; exp_upd = 16'd1;
        checks++;
        if (update_pulse !== 1'b1) begin
            errors++;
            $display("FAIL commit_pulse: got %b expected 1", update_pulse);
        end
        check_all("commit_T3", 1'b0);
        tick(1);
        checks++;
        if (update_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got %b expected 0", update_pulse);
        end
    endtask

    task automatic test_restart();
        sync_in = 32'h1;
        tick(2);
        sync_in = 32'h3;
        exp_q.push_back(32'h3);
        tick(1);
        exp_gl = exp_gl + 16'd1;
        check_all("restart_T2", 1'b1);
        tick(2);
        check_all("restart_T4", 1'b1);
        tick(1);
        exp_qual = 32'h3; exp_upd = exp_upd + 16'd1;
        check_all("restart_commit_T5", 1'b0);
    endtask

    task automatic test_abort();
        sync_in = 32'h7;
        tick(1);
        check_all("abort_T", 1'b1);
        sync_in = 32'h3;
        tick(1);
        exp_gl = (exp_gl == 16'hFFFF) ? exp_gl : exp_gl + 16'd1;
        check_all("abort_T1", 1'b0);
        tick(4);
        check_all("abort_quiet", 1'b0);
    endtask

    task automatic test_enable();
        sync_in = 32'h55;
        tick(2);
        en = 1'b0;
        tick(1);
        check_all("en_drop", 1'b0);
        tick(3);
        check_all("en_frozen", 1'b0);
        en = 1'b1;
        exp_q.push_back(32'h55);
        tick(1);
        check_all("en_resettle", 1'b1);
        tick(2);
        check_all("en_resettle_U2", 1'b1);
        tick(1);
        exp_qual = 32'h55; exp_upd = exp_upd + 16'd1;
        check_all("en_commit_U3", 1'b0);
    endtask

    task automatic test_saturate_and_clear();
        force dut.update_cnt_q = 16'hFFFE;
        force dut.glitch_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.update_cnt_q;
        release dut.glitch_cnt_q;
        tick(1);
        exp_upd = 16'hFFFE; exp_gl = 16'hFFFF;
        check_all("sat_preload", 1'b0);
        sync_in = 32'h11;
        exp_q.push_back(32'h11);
        tick(5);
        exp_qual = 32'h11; exp_upd = 16'hFFFF;
        check_all("sat_reach", 1'b0);
        sync_in = 32'h22;
        exp_q.push_back(32'h22);
        tick(5);
        exp_qual = 32'h22;
        check_all("sat_hold_upd", 1'b0);
        // Glitch counter already at max: abort must not wrap it
        sync_in = 32'h7;
        tick(1);
        sync_in = 32'h22;
        tick(1);
        check_all("sat_hold_glitch", 1'b0);
        // Clear coincident with a commit edge
        sync_in = 32'h33;
        exp_q.push_back(32'h33);
        tick(3);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        exp_qual = 32'h33; exp_upd = '0; exp_gl = '0;
        check_all("clr_with_commit", 1'b0);
    endtask

    task automatic test_async_reset();
        sync_in = 32'h99;
        tick(2);
        check_all("rst_pre_settle", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_qual = '0; exp_upd = '0; exp_gl = '0;
        checks++;
        if (update_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_pulse: got %b expected 0", update_pulse);
        end
        check_all("async_rst_immediate", 1'b0);
        tick(2);
        rst = 1'b0;
        exp_q.push_back(32'h99);
        tick(1);
        check_all("rst_requalify_T", 1'b1);
        tick(2);
        check_all("rst_requalify_T2", 1'b1);
        tick(1);
        exp_qual = 32'h99; exp_upd = 16'd1;
        check_all("rst_requalify_commit", 1'b0);
    endtask

    initial begin
        test_reset();
        test_commit();
        test_restart();
        test_abort();
        test_enable();
        test_saturate_and_clear();
        test_async_reset();
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d commits missing, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_array_qualify.md
CDC_ARRAY_QUALIFY -- requirements
Module: cdc_array_qualify

Purpose: destination-domain stage directly downstream of the multi-bit array synchronizer; qualifies the synchronized bus as stable before use, because per-bit synchronization gives no word coherency.

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bus width (1-1024).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before commit (2-255).
REQ-003 SHALL have parameter INIT_VALUE, default 0: WIDTH-bit reset value of the qualified output.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 sync_in  input  WIDTH  synchronized bus from the upstream array synchronizer.
REQ-007 en  input  1  qualification enable; low holds qual_out frozen.
REQ-008 cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-009 qual_out  output  WIDTH  last committed stable value (registered).
REQ-010 update_pulse  output  1  one-cycle strobe, high in the cycle qual_out first shows a new committed value.
REQ-011 settling  output  1  high while a candidate is being qualified (state SETTLE).
REQ-012 update_cnt  output  16  saturating count of commits.
REQ-013 glitch_cnt  output  16  saturating count of aborted or restarted candidates.

Function
REQ-014 SHALL implement two states, IDLE and SETTLE, with internal registers cand (WIDTH) and cnt (8 bits).
REQ-015 IDLE, en=1, sync_in != qual_out at edge T: cand<=sync_in, cnt<=1, go SETTLE.
REQ-016 SETTLE, sync_in == cand and cnt < STABLE_CYCLES-1: cnt<=cnt+1.
REQ-017 SETTLE, sync_in == cand and cnt == STABLE_CYCLES-1: qual_out<=cand, update_pulse<=1, update_cnt increments, go IDLE; with no further change, commit happens at edge T+STABLE_CYCLES-1.
REQ-018 SETTLE, sync_in != cand and sync_in != qual_out: cand<=sync_in, cnt<=1, glitch_cnt increments, stay SETTLE (restart).
REQ-019 SETTLE, sync_in == qual_out: go IDLE, no commit, no pulse, glitch_cnt increments.
REQ-020 en=0 at any edge: state<=IDLE, cnt<=0, qual_out held, no pulse, no counter increment; an in-progress candidate is discarded without counting a glitch.
REQ-021 update_pulse SHALL be low in every cycle not immediately following a commit edge; back-to-back commits are impossible (minimum spacing STABLE_CYCLES cycles).
REQ-022 settling SHALL be a registered decode of state==SETTLE.
REQ-023 update_cnt and glitch_cnt SHALL saturate at 0xFFFF and never wrap.
REQ-024 cnt_clr=1 SHALL zero both counters at that edge; simultaneous increment is lost (clear wins).
REQ-025 qual_out SHALL change only on a commit edge or reset; it never shows a partially updated word.

Reset
REQ-026 rst high SHALL immediately set: state IDLE, qual_out=INIT_VALUE, cand=INIT_VALUE, cnt=0, update_pulse=0, settling=0, update_cnt=0, glitch_cnt=0.
REQ-027 Reset asserted mid-SETTLE SHALL discard the candidate with no commit and no pulse.
REQ-028 After deassertion with sync_in != INIT_VALUE and en=1, the block SHALL qualify and commit normally per REQ-015..017.

Verification
REQ-029 STABLE_CYCLES=4, qual_out=0; sync_in 0->0xA5A5A5A5 held at edge T -> settling high from T, qual_out=0xA5A5A5A5 and update_pulse=1 for one cycle after edge T+3, update_cnt=1.
REQ-030 sync_in 0x1 at T, 0x3 at T+2, held -> restart; commit of 0x3 at T+5, glitch_cnt=1, update_cnt=1, no commit of 0x1.
REQ-031 sync_in 0x0->0x7 at T, back to 0x0 at T+1 -> IDLE at T+1, qual_out stays 0x0, no pulse, glitch_cnt=1.
REQ-032 en dropped at T+2 of a settle -> no commit, settling low after T+2, counters unchanged; en raised with sync_in still different -> fresh settle, commit 3 edges later.
REQ-033 Preload update_cnt to 0xFFFF via 65535 commits -> one more commit leaves 0xFFFF; cnt_clr coincident with a commit -> update_cnt=0 while qual_out still updates.
REQ-034 rst pulsed mid-SETTLE, asynchronous to clk -> all outputs return to reset values immediately; no update_pulse during or after reset until a full new qualification completes.
